instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register. It issues sequential PC requests to a handshaked instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents them to the IF/ID register. It supports stall through `out_ready`, which is driven by `IF_ID_write`. It also supports redirect from branch resolution: `pc_src` together with the EX/MEM branch target. Responses that belong to the squashed stream are discarded.

## Interface
- `DEPTH`, 4: number of FIFO entries. Must be a power of two, at least 2. Also bounds buffered plus in-flight fetches.
- `RESET_PC`, 64'h0: first fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  64  fetch address (current `fetch_pc`).
- `imem_resp_valid`  in  1  response valid. Responses arrive in order, one per accepted request, at least 1 cycle after acceptance.
- `imem_resp_instr`  in  32  returned instruction.
- `redirect`  in  1  branch taken; squash and refetch.
- `redirect_pc`  in  64  new fetch address.
- `out_valid`  out  1  FIFO head valid.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  64  head PC.
- `out_ready`  in  1  consumer takes the head (IF_ID_write).

## Operation
- **State:**
  - `fetch_pc`: next request address.
  - `resp_pc`: PC of the next kept response.
  - `outstanding`: accepted requests not yet responded. Width clog2(DEPTH+1).
  - `drop_cnt`: responses still to discard.
  - `count`: FIFO occupancy.
  - `state` ∈ {FETCH, DRAIN}.
- **State machine:**
  - FETCH when `drop_cnt`==0. DRAIN when `drop_cnt`!=0.
  - FETCH→DRAIN on a redirect with old responses still pending.
  - DRAIN→FETCH when the last dropped response arrives with no new redirect.
  - A redirect while in DRAIN reloads `drop_cnt`.
- **Credit:** `live` = `outstanding` − `drop_cnt`. A request is issued when `count` + `live` < DEPTH. The check uses registered values only; a pop in the same cycle does not add credit.
- **Request valid:** `imem_req_valid` = !`reset` & !`redirect` & credit.
- **Request acceptance** (`imem_req_valid` & `imem_req_ready`): `fetch_pc` += 4 (64-bit wrap) and `outstanding`++.
- **Response:** `outstanding`-- on every response.
  - If `drop_cnt`!=0: discard and decrement `drop_cnt`.
  - Otherwise: push {instr, `resp_pc`} and `resp_pc` += 4.
  - The FIFO never overflows by construction. An overflow is an assertion failure.
- **Pop:** when `out_valid` & `out_ready`, `count`--. A simultaneous push and pop leaves `count` unchanged.
- **Redirect** (highest priority):
  - FIFO cleared (`count`=0, pointers reset); any pop that cycle is ignored.
  - `fetch_pc` and `resp_pc` load `redirect_pc`.
  - `drop_cnt` ← `outstanding` − `imem_resp_valid`. A response in the redirect cycle belongs to the old stream and is discarded.
  - No request is issued that cycle.
- **Outputs:** `out_instr` and `out_pc` are the head entry, and are don't-care when `out_valid`=0.

## Timing
- **Reset:** while `reset`=1 and on the cycle it is sampled:
  - `fetch_pc` = `resp_pc` = `RESET_PC`.
  - `outstanding` = `drop_cnt` = `count` = 0; state = FETCH.
  - `out_valid` = 0, `imem_req_valid` = 0.
  - The first request is issued in the first cycle with `reset`=0.
- **Reset mid-operation:** all in-flight responses are abandoned. The memory must be reset in the same cycle.
- **Latency:** request accepted at t, response at t+L (L≥1), push at end of t+L, `out_valid`=1 at t+L+1.
- **Throughput:** with L=1, always-ready memory and `out_ready`=1, one instruction per cycle in steady state.
- **Redirect:** asserted at t gives `out_valid`=0 at t+1 and a request to `redirect_pc` at t+1 if credit allows. The first new instruction is visible no earlier than t+3 (L=1).
- **Full:** `count`=DEPTH holds `imem_req_valid`=0 until a pop. The request resumes the cycle after the pop.
- **Empty:** `out_valid`=0; `out_ready` is ignored.

## Test plan
- **Reset and stream:**
  - Stimulus: RESET_PC=0, memory L=1 always ready, `out_ready`=1.
  - Response: `out_pc` sequence 0,4,8,… with the matching instructions; first `out_valid` 2 cycles after reset release; then one per cycle.
- **Stall/full:**
  - Stimulus: `out_ready`=0 for 10 cycles, DEPTH=4.
  - Response: exactly 4 requests accepted, `count`=4, `imem_req_valid`=0. After release, entries drain as PCs 0,4,8,12 and fetching resumes at 16.
- **Redirect with in-flight responses:**
  - Stimulus: memory L=3; redirect to 0x100 while 3 requests are outstanding.
  - Response: 3 responses dropped, no `out_valid` from the old stream, next `out_pc`=0x100.
- **Redirect coincident with response:**
  - Stimulus: `redirect` and `imem_resp_valid` in the same cycle.
  - Response: that response is not pushed; `drop_cnt` = `outstanding`−1.
- **Back-to-back redirects:**
  - Stimulus: redirect to 0x200 in DRAIN, then to 0x300 on the next cycle.
  - Response: only 0x300,0x304… emerge.
- **Backpressure and wrap:**
  - Stimulus: random `imem_req_ready`/`out_ready`; redirect to 64'hFFFF_FFFF_FFFF_FFF8.
  - Response: PCs …FFF8, …FFFC, 0x0, 0x4 in order; no loss or duplication against the scoreboard.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end ahead of IF/ID. It issues sequential PC requests and
// buffers {instr, pc} in a small FIFO. On a redirect it squashes the FIFO and drops stale responses.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_instr,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [DEPTH];

  logic [CW-1:0] live;
  logic          credit, req_fire, push, pop;

  // Credit counts buffered entries plus live in-flight fetches, using registered values only.
  assign live           = outstanding_q - drop_cnt_q;
  assign credit         = ({1'b0, count_q} + {1'b0, live}) < DEPTH_W;
  assign imem_req_valid = !reset && !redirect && credit;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = !reset && (count_q != '0);
  assign out_instr = mem_q[rd_ptr_q].instr;
  assign out_pc    = mem_q[rd_ptr_q].pc;

  assign push = !reset && !redirect && imem_resp_valid && (drop_cnt_q == '0);
  assign pop  = out_valid && out_ready && !redirect;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect) begin
      // A response arriving now belongs to the old stream, so it is not counted as still to drop.
      fetch_pc_d    = redirect_pc;
      resp_pc_d     = redirect_pc;
      outstanding_d = outstanding_q - CW'(imem_resp_valid);
      drop_cnt_d    = outstanding_q - CW'(imem_resp_valid);
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + 64'd4;
          wr_ptr_d  = wr_ptr_q + PW'(1);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    state_d = (drop_cnt_d != '0) ? DRAIN : FETCH;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read once count_q marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{instr: imem_resp_instr, pc: resp_pc_q};
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == DEPTH_C)));

  resp_underflow_a: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && (outstanding_q == '0)));

  state_consistent_a: assert property (@(posedge clk) disable iff (reset)
    ((state_q == DRAIN) == (drop_cnt_q != '0)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. It uses an in-order fixed-latency memory model
// and a next-PC scoreboard that checks every instruction taken from the queue.
module tb_instr_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_instr = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_instr (imem_resp_instr),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_ready       (out_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ pc[63:32] ^ 32'h6F00_0013;
  endfunction

  // Memory model: accepted addresses with the cycle their response becomes due.
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  int          cyc       = 0;
  int          lat       = 1;
  bit          rand_mode = 1'b0;
  logic [63:0] exp_pc    = RESET_PC;
  int          acc_cnt   = 0;
  int          pop_cnt   = 0;

  logic        s_req_valid, s_out_valid, s_popped;
  logic [63:0] s_req_addr, s_pop_pc;

  task automatic tick();
    logic acc;
    if (rand_mode) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = 1'($urandom_range(0, 1));
    end
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_instr = instr_of(mq_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_instr = '0;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_out_valid = out_valid;
    s_pop_pc    = out_pc;
    s_popped    = out_valid && out_ready && !redirect && !reset;
    if (s_popped) begin
      check("pop_pc", out_pc, exp_pc);
      check("pop_instr", out_instr, instr_of(exp_pc));
      exp_pc = exp_pc + 64'd4;
      pop_cnt++;
    end
    if (reset) exp_pc = RESET_PC;
    else if (redirect) exp_pc = redirect_pc;
    acc = imem_req_valid && imem_req_ready;
    @(posedge clk);
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_resp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (acc) begin
        mq_addr.push_back(s_req_addr);
        mq_due.push_back(cyc + lat);
        acc_cnt++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic wait_pop(input int max_cycles, output logic [63:0] pc, output logic ok);
    pc = '1;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (s_popped) begin
        pc = s_pop_pc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset(input int n);
    reset    = 1'b1;
    redirect = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  logic [63:0] pc;
  logic        ok;
  int          n_out;

  initial begin
    // Reset and stream: L=1, always-ready memory and consumer.
    lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_req_valid", s_req_valid, 1'b0);
    check("rst_out_valid", s_out_valid, 1'b0);
    check("rst_req_addr", s_req_addr, RESET_PC);
    check("rst_count", dut.count_q, 0);
    reset = 1'b0;
    tick();
    check("s1_req_valid_c0", s_req_valid, 1'b1);
    check("s1_req_addr_c0", s_req_addr, 64'h0);
    check("s1_out_valid_c0", s_out_valid, 1'b0);
    tick();
    check("s1_out_valid_c1", s_out_valid, 1'b0);
    check("s1_req_addr_c1", s_req_addr, 64'h4);
    tick();
    check("s1_out_valid_c2", s_out_valid, 1'b1);
    check("s1_out_pc_c2", s_pop_pc, 64'h0);
    pop_cnt = 0;
    repeat (8) tick();
    check("s1_throughput", pop_cnt, 8);

    // Stall/full: reset mid-stream with a non-empty FIFO, then hold out_ready low.
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("s2_rst_out_valid", s_out_valid, 1'b0);
    check("s2_rst_req_valid", s_req_valid, 1'b0);
    tick();
    reset = 1'b0;
    acc_cnt = 0;
    repeat (10) tick();
    check("s2_accepted", acc_cnt, 4);
    check("s2_count_full", dut.count_q, 4);
    check("s2_req_held", s_req_valid, 1'b0);
    out_ready = 1'b1;
    pop_cnt = 0;
    tick();
    check("s2_req_pop_cycle", s_req_valid, 1'b0);
    tick();
    check("s2_req_resume", s_req_valid, 1'b1);
    check("s2_req_resume_addr", s_req_addr, 64'h10);
    repeat (2) tick();
    check("s2_drained", pop_cnt, 4);
    check("s2_next_pc", exp_pc, 64'h10);

    // Redirect with three requests in flight, L=3; the oldest responds in the redirect cycle.
    lat = 3;
    apply_reset(2);
    repeat (3) tick();
    check("s3_outstanding", dut.outstanding_q, 3);
    redirect = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect = 1'b0;
    check("s3_drop_cnt", dut.drop_cnt_q, 2);
    tick();
    check("s3_req_valid", s_req_valid, 1'b1);
    check("s3_req_addr", s_req_addr, 64'h100);
    check("s3_out_valid", s_out_valid, 1'b0);
    wait_pop(20, pc, ok);
    check("s3_pop_seen", ok, 1'b1);
    check("s3_first_pc", pc, 64'h100);
    check("s3_drop_done", dut.drop_cnt_q, 0);

    // Redirect coincident with a response, L=2.
    lat = 2;
    apply_reset(2);
    repeat (2) tick();
    n_out = mq_addr.size();
    redirect = 1'b1;
    redirect_pc = 64'h40;
    tick();
    redirect = 1'b0;
    check("s4_drop_cnt", dut.drop_cnt_q, 64'(n_out - 1));
    check("s4_not_pushed", dut.count_q, 0);
    wait_pop(20, pc, ok);
    check("s4_pop_seen", ok, 1'b1);
    check("s4_first_pc", pc, 64'h40);

    // Back-to-back redirects: the second one lands while draining.
    lat = 3;
    apply_reset(2);
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 64'h200;
    tick();
    check("s5_drain_state", dut.drop_cnt_q, 2);
    redirect_pc = 64'h300;
    tick();
    redirect = 1'b0;
    check("s5_drop_reload", dut.drop_cnt_q, 1);
    wait_pop(20, pc, ok);
    check("s5_first_pc", pc, 64'h300);
    wait_pop(20, pc, ok);
    check("s5_second_pc", pc, 64'h304);

    // Random backpressure with a redirect that wraps the 64-bit PC.
    lat = 2;
    apply_reset(2);
    rand_mode = 1'b1;
    repeat (20) tick();
    redirect = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    redirect = 1'b0;
    wait_pop(200, pc, ok);
    check("s6_pc0", pc, 64'hFFFF_FFFF_FFFF_FFF8);
    wait_pop(200, pc, ok);
    check("s6_pc1", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_pop(200, pc, ok);
    check("s6_pc2", pc, 64'h0);
    wait_pop(200, pc, ok);
    check("s6_pc3", pc, 64'h4);
    repeat (150) tick();
    rand_mode = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    pop_cnt = 0;
    repeat (20) tick();
    check("s6_stream_alive", pop_cnt >= 15, 1'b1);
    check("s6_drop_idle", dut.drop_cnt_q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
